ftch_stage: RTL and testbench

- MIPS instruction-fetch stage. Owns the PC and issues word-aligned requests to instruction memory.
- Buffers returned instructions in a small in-order queue and presents them to decode over a valid/ready handshake.
- Consumes mem_ftch_pkt from the memory stage as a taken-branch/jump/exception redirect: flushes the queue and discards stale in-flight responses.

---
 rtl/ftch_pkg.sv | 17 +
 rtl/mem_ftch_pkg.sv | 11 +
 rtl/ftch_fifo.sv | 60 ++++++
 rtl/ftch_stage.sv | 150 +++++++++++++++
 tb/tb_ftch_stage.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/ftch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package ftch_pkg;

    localparam int unsigned INSTR_W       = 32;
    localparam logic [31:0] RESET_PC_DFLT = 32'hBFC0_0000;

    typedef enum logic {
        WAKE = 1'b0,
        RUN  = 1'b1
    } ftch_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [31:0]        pc;
    } ftch_dcd_pkt_t;

endpackage

// File: rtl/mem_ftch_pkg.sv
// Memory-stage to fetch-stage redirect packet (taken branch, jump, exception).
package mem_ftch_pkg;

    localparam int unsigned MEM_FTCH_ADDR_W = 32;

    typedef struct packed {
        logic                       vld;
        logic [MEM_FTCH_ADDR_W-1:0] tgt_pc;
    } mem_ftch_pkt_t;

endpackage

// File: rtl/ftch_fifo.sv
// Synchronous FIFO with single-cycle flush; DEPTH must be a power of two.
module ftch_fifo #(
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: every signal gets a default before any branch, so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            cnt_d = cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    // NOTE: state registers use non-blocking assignment so all flops update together.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // NOTE: storage is not reset; the count alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/ftch_stage.sv
// MIPS instruction-fetch stage: PC, credit-limited imem requests, in-order fetch queue.
// Optional FTCH_PERF_CNT_EN adds redirect and decode-stall counters.
module ftch_stage
    import mem_ftch_pkg::*;
    import ftch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DFLT[ADDR_W-1:0],
    parameter int unsigned       FQ_DEPTH = 2
) (
    input  logic               clk,
    input  logic               resetn,
    input  mem_ftch_pkt_t      mem_ftch_pkt,
    output logic               imem_req_vld,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_req_rdy,
    input  logic               imem_rsp_vld,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               ftch_dcd_vld,
    output logic [INSTR_W-1:0] ftch_dcd_instr,
    output logic [ADDR_W-1:0]  ftch_dcd_pc,
    input  logic               ftch_dcd_rdy
`ifdef FTCH_PERF_CNT_EN
    ,
    output logic [31:0]        ftch_redirect_cnt,
    output logic [31:0]        ftch_stall_cnt
`endif
);

    localparam int unsigned CNT_W = $clog2(FQ_DEPTH) + 1;
    localparam int unsigned QW    = ADDR_W + INSTR_W;

    ftch_state_e       state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  drop_q, drop_d;

    logic              redirect;
    logic              req_acc;
    logic              rsp_keep;
    logic              dcd_pop;
    logic [CNT_W-1:0]  fq_cnt;
    logic [CNT_W-1:0]  outst_cnt;
    logic [CNT_W-1:0]  outst_nxt;
    logic [CNT_W:0]    credit_used;
    logic [ADDR_W-1:0] shadow_pc;
    logic [QW-1:0]     fq_head;

    assign redirect = mem_ftch_pkt.vld;

    // The shadow FIFO holds one PC per accepted request and is never flushed,
    // so its occupancy is exactly the number of outstanding requests.
    ftch_fifo #(.WIDTH(ADDR_W), .DEPTH(FQ_DEPTH)) u_pc_shadow (
        .clk     (clk),
        .resetn  (resetn),
        .flush_i (1'b0),
        .push_i  (req_acc),
        .wdata_i (pc_q),
        .pop_i   (imem_rsp_vld),
        .rdata_o (shadow_pc),
        .count_o (outst_cnt)
    );

    ftch_fifo #(.WIDTH(QW), .DEPTH(FQ_DEPTH)) u_instr_q (
        .clk     (clk),
        .resetn  (resetn),
        .flush_i (redirect),
        .push_i  (rsp_keep),
        .wdata_i ({shadow_pc, imem_rsp_data}),
        .pop_i   (dcd_pop),
        .rdata_o (fq_head),
        .count_o (fq_cnt)
    );

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        drop_d         = drop_q;
        imem_req_vld   = 1'b0;
        imem_req_addr  = '0;
        ftch_dcd_vld   = 1'b0;
        ftch_dcd_instr = '0;
        ftch_dcd_pc    = '0;

        if (state_q == WAKE) state_d = RUN;

        // Queue entries plus requests in flight may never exceed the queue depth.
        credit_used = {1'b0, fq_cnt} + {1'b0, outst_cnt};
        if (state_q == RUN && !redirect && credit_used < (CNT_W+1)'(FQ_DEPTH)) begin
            imem_req_vld  = 1'b1;
            imem_req_addr = pc_q;
        end
        req_acc = imem_req_vld && imem_req_rdy;

        if (state_q == RUN && !redirect && fq_cnt != '0) begin
            ftch_dcd_vld   = 1'b1;
            ftch_dcd_instr = fq_head[INSTR_W-1:0];
            ftch_dcd_pc    = fq_head[QW-1:INSTR_W];
        end
        dcd_pop = ftch_dcd_vld && ftch_dcd_rdy;

        rsp_keep  = imem_rsp_vld && (drop_q == '0) && !redirect;
        outst_nxt = outst_cnt + CNT_W'(req_acc) - CNT_W'(imem_rsp_vld);

        if (redirect) begin
            drop_d = outst_nxt;
            pc_d   = mem_ftch_pkt.tgt_pc[ADDR_W-1:0] & ~ADDR_W'(3);
        end else begin
            if (imem_rsp_vld && drop_q != '0) drop_d = drop_q - CNT_W'(1);
            if (req_acc) pc_d = pc_q + ADDR_W'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= WAKE;
            pc_q    <= RESET_PC;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
        end
    end

`ifdef FTCH_PERF_CNT_EN
    logic [31:0] redirect_cnt_q, redirect_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        redirect_cnt_d = redirect_cnt_q;
        stall_cnt_d    = stall_cnt_q;
        if (redirect) redirect_cnt_d = redirect_cnt_q + 32'd1;
        if (ftch_dcd_vld && !ftch_dcd_rdy) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            redirect_cnt_q <= '0;
            stall_cnt_q    <= '0;
        end else begin
            redirect_cnt_q <= redirect_cnt_d;
            stall_cnt_q    <= stall_cnt_d;
        end
    end

    assign ftch_redirect_cnt = redirect_cnt_q;
    assign ftch_stall_cnt    = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ftch_stage.sv
// Directed bench for ftch_stage: table-driven fill/stall flow plus redirect, wrap and reset sequences.
module tb_ftch_stage;
    import mem_ftch_pkg::*;

    localparam logic [31:0] B = 32'hBFC0_0000;

    logic          clk;
    logic          resetn;
    mem_ftch_pkt_t mem_ftch_pkt;
    logic          imem_req_vld;
    logic [31:0]   imem_req_addr;
    logic          imem_req_rdy;
    logic          imem_rsp_vld;
    logic [31:0]   imem_rsp_data;
    logic          ftch_dcd_vld;
    logic [31:0]   ftch_dcd_instr;
    logic [31:0]   ftch_dcd_pc;
    logic          ftch_dcd_rdy;
`ifdef FTCH_PERF_CNT_EN
    logic [31:0]   ftch_redirect_cnt;
    logic [31:0]   ftch_stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    // Addresses accepted by the memory model and not yet answered, oldest first.
    logic [31:0] inflight [$];

    typedef struct {
        logic        rdy;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_dv;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs [17];

    ftch_stage #(.ADDR_W(32), .RESET_PC(B), .FQ_DEPTH(2)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .mem_ftch_pkt      (mem_ftch_pkt),
        .imem_req_vld      (imem_req_vld),
        .imem_req_addr     (imem_req_addr),
        .imem_req_rdy      (imem_req_rdy),
        .imem_rsp_vld      (imem_rsp_vld),
        .imem_rsp_data     (imem_rsp_data),
        .ftch_dcd_vld      (ftch_dcd_vld),
        .ftch_dcd_instr    (ftch_dcd_instr),
        .ftch_dcd_pc       (ftch_dcd_pc),
        .ftch_dcd_rdy      (ftch_dcd_rdy)
`ifdef FTCH_PERF_CNT_EN
        ,
        .ftch_redirect_cnt (ftch_redirect_cnt),
        .ftch_stall_cnt    (ftch_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return addr ^ 32'hA5A5_5A5A;
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // One clock cycle: drive inputs just after a negedge, compare before the posedge,
    // record any accepted request, and return at the following negedge.
    task automatic step(input string nm, input logic rdy, input logic rsp_en,
                        input logic redir, input logic [31:0] tgt,
                        input logic exp_req, input logic [31:0] exp_addr,
                        input logic exp_dv, input logic [31:0] exp_pc);
        ftch_dcd_rdy        = rdy;
        imem_req_rdy        = 1'b1;
        mem_ftch_pkt.vld    = redir;
        mem_ftch_pkt.tgt_pc = tgt;
        if (rsp_en && inflight.size() > 0) begin
            imem_rsp_vld  = 1'b1;
            imem_rsp_data = mem_word(inflight.pop_front());
        end else begin
            imem_rsp_vld  = 1'b0;
            imem_rsp_data = '0;
        end
        #1;
        check($sformatf("%s req_vld", nm), {31'b0, imem_req_vld}, {31'b0, exp_req});
        if (exp_req) check($sformatf("%s req_addr", nm), imem_req_addr, exp_addr);
        check($sformatf("%s dcd_vld", nm), {31'b0, ftch_dcd_vld}, {31'b0, exp_dv});
        if (exp_dv) begin
            check($sformatf("%s dcd_pc", nm), ftch_dcd_pc, exp_pc);
            check($sformatf("%s dcd_instr", nm), ftch_dcd_instr, mem_word(exp_pc));
        end
        if (imem_req_vld && imem_req_rdy) inflight.push_back(imem_req_addr);
        @(negedge clk);
    endtask

    initial begin
        resetn              = 1'b0;
        mem_ftch_pkt.vld    = 1'b0;
        mem_ftch_pkt.tgt_pc = '0;
        imem_req_rdy        = 1'b1;
        imem_rsp_vld        = 1'b0;
        imem_rsp_data       = '0;
        ftch_dcd_rdy        = 1'b0;

        // Fill with decode stalled, release, then steady fetching with 1-cycle memory.
        vecs[0]  = '{1'b0, 1'b0, 32'h0,     1'b0, 32'h0};
        vecs[1]  = '{1'b0, 1'b1, B + 32'h0, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 1'b1, B + 32'h4, 1'b0, 32'h0};
        for (int i = 3; i <= 10; i++) vecs[i] = '{1'b0, 1'b0, 32'h0, 1'b1, B};
        vecs[11] = '{1'b1, 1'b0, 32'h0,      1'b1, B + 32'h0};
        vecs[12] = '{1'b1, 1'b1, B + 32'h8,  1'b1, B + 32'h4};
        vecs[13] = '{1'b1, 1'b1, B + 32'hC,  1'b0, 32'h0};
        vecs[14] = '{1'b1, 1'b0, 32'h0,      1'b1, B + 32'h8};
        vecs[15] = '{1'b1, 1'b1, B + 32'h10, 1'b1, B + 32'hC};
        vecs[16] = '{1'b1, 1'b1, B + 32'h14, 1'b0, 32'h0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset req_vld", {31'b0, imem_req_vld}, 32'h0);
        check("reset dcd_vld", {31'b0, ftch_dcd_vld}, 32'h0);
        check("reset dcd_instr", ftch_dcd_instr, 32'h0);
        check("reset dcd_pc", ftch_dcd_pc, 32'h0);
        resetn = 1'b1;

        for (int i = 0; i < 17; i++)
            step($sformatf("vec%0d", i), vecs[i].rdy, 1'b1, 1'b0, 32'h0,
                 vecs[i].exp_req, vecs[i].exp_addr, vecs[i].exp_dv, vecs[i].exp_pc);

        // Two requests outstanding when redirected: both responses are discarded.
        step("A1", 1'b1, 1'b0, 1'b0, 32'h0,          1'b0, 32'h0,        1'b1, B + 32'h10);
        step("A2", 1'b1, 1'b0, 1'b0, 32'h0,          1'b1, B + 32'h18,   1'b0, 32'h0);
        step("A3", 1'b1, 1'b0, 1'b0, 32'h0,          1'b0, 32'h0,        1'b0, 32'h0);
        step("A4", 1'b1, 1'b0, 1'b1, 32'h8000_0100,  1'b0, 32'h0,        1'b0, 32'h0);
        step("A5", 1'b1, 1'b1, 1'b0, 32'h0,          1'b0, 32'h0,        1'b0, 32'h0);
        step("A6", 1'b1, 1'b1, 1'b0, 32'h0,          1'b1, 32'h8000_0100, 1'b0, 32'h0);
        step("A7", 1'b1, 1'b1, 1'b0, 32'h0,          1'b1, 32'h8000_0104, 1'b0, 32'h0);
        step("A8", 1'b1, 1'b1, 1'b0, 32'h0,          1'b0, 32'h0,        1'b1, 32'h8000_0100);

        // Redirect to an unaligned target in the same cycle as a response.
        step("B1", 1'b1, 1'b1, 1'b0, 32'h0,          1'b1, 32'h8000_0108, 1'b1, 32'h8000_0104);
        step("B2", 1'b1, 1'b1, 1'b1, 32'h8000_0103,  1'b0, 32'h0,        1'b0, 32'h0);
        step("B3", 1'b1, 1'b1, 1'b0, 32'h0,          1'b1, 32'h8000_0100, 1'b0, 32'h0);
        step("B4", 1'b1, 1'b1, 1'b0, 32'h0,          1'b1, 32'h8000_0104, 1'b0, 32'h0);
        step("B5", 1'b1, 1'b1, 1'b0, 32'h0,          1'b0, 32'h0,        1'b1, 32'h8000_0100);

        // Redirect with a queued entry hides it, then the PC wraps past the top of memory.
        step("C1", 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC,  1'b0, 32'h0,        1'b0, 32'h0);
        step("C2", 1'b1, 1'b1, 1'b0, 32'h0,          1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
        step("C3", 1'b1, 1'b1, 1'b0, 32'h0,          1'b1, 32'h0000_0000, 1'b0, 32'h0);
        step("C4", 1'b1, 1'b1, 1'b0, 32'h0,          1'b0, 32'h0,        1'b1, 32'hFFFF_FFFC);
        step("C5", 1'b1, 1'b1, 1'b0, 32'h0,          1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000);

        // Second redirect while the first is still draining.
        step("D1", 1'b1, 1'b0, 1'b0, 32'h0,          1'b1, 32'h0000_0008, 1'b0, 32'h0);
        step("D2", 1'b1, 1'b0, 1'b1, 32'h0000_1000,  1'b0, 32'h0,        1'b0, 32'h0);
        step("D3", 1'b1, 1'b1, 1'b1, 32'h0000_2000,  1'b0, 32'h0,        1'b0, 32'h0);
        step("D4", 1'b1, 1'b1, 1'b0, 32'h0,          1'b1, 32'h0000_2000, 1'b0, 32'h0);
        step("D5", 1'b1, 1'b1, 1'b0, 32'h0,          1'b1, 32'h0000_2004, 1'b0, 32'h0);
        step("D6", 1'b1, 1'b1, 1'b0, 32'h0,          1'b0, 32'h0,        1'b1, 32'h0000_2000);

`ifdef FTCH_PERF_CNT_EN
        check("perf redirect_cnt", ftch_redirect_cnt, 32'd5);
        check("perf stall_cnt", ftch_stall_cnt, 32'd8);
`endif

        // Reset in the middle of traffic abandons everything and restarts at RESET_PC.
        resetn           = 1'b0;
        mem_ftch_pkt.vld = 1'b0;
        imem_rsp_vld     = 1'b0;
        inflight.delete();
        @(posedge clk);
        @(negedge clk);
        #1;
        check("E reset req_vld", {31'b0, imem_req_vld}, 32'h0);
        check("E reset dcd_vld", {31'b0, ftch_dcd_vld}, 32'h0);
        check("E reset dcd_pc", ftch_dcd_pc, 32'h0);
`ifdef FTCH_PERF_CNT_EN
        check("E reset redirect_cnt", ftch_redirect_cnt, 32'd0);
        check("E reset stall_cnt", ftch_stall_cnt, 32'd0);
`endif
        resetn = 1'b1;
        step("E1", 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        step("E2", 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, B,     1'b0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
